// File: rtl/hart_meter.sv
// hart_meter: beat-interval meter on the slow clock.
// Averages the last four beat intervals and divides them into a scaled rate.
module hart_meter #(
  parameter int RATE_NUM = 3000,
  parameter int MIN_GAP  = 20,
  parameter int MAX_GAP  = 300,
  parameter int CNT_W    = 12
) (
  input  logic       slow,
  input  logic       reset,
  input  logic       beat,
  output logic [5:0] hart,
  output logic       hartValid,
  output logic       lost
);
  localparam logic [1:0] WAIT_FIRST = 2'd0;
  localparam logic [1:0] FILL       = 2'd1;
  localparam logic [1:0] DIV        = 2'd2;
  localparam logic [1:0] TRACK      = 2'd3;

  localparam int SW = CNT_W + 2;
  localparam int IW = $clog2(CNT_W + 1);
  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_GAP);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_GAP);
  localparam logic [CNT_W-1:0] NUM_C = CNT_W'(RATE_NUM);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
  localparam logic [IW-1:0] LAST_IT = IW'(CNT_W - 1);

  // [0] first sync stage, [1] second stage, [2] second stage delayed
  logic [2:0]       sync_q, sync_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hist_q [4];
  logic [CNT_W-1:0] hist_d [4];
  logic [SW-1:0]    sum_q, sum_d;
  logic [2:0]       fill_q, fill_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] dvd_q, dvd_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] dvs_q, dvs_d;
  logic [IW-1:0]    it_q, it_d;
  logic [5:0]       hart_q, hart_d;
  logic             valid_q, valid_d;
  logic             lost_q, lost_d;

  logic             edge_w, accept, record;
  logic             timeout, done, start, ge;
  logic [CNT_W:0]   trial, diff;
  logic [CNT_W-1:0] quo_n;

  always_comb begin
    sync_d  = {sync_q[1], sync_q[0], beat};
    edge_w  = sync_q[1] & ~sync_q[2];
    accept  = edge_w & ((state_q == WAIT_FIRST) | (cnt_q >= MIN_C));
    record  = accept & (state_q != WAIT_FIRST);
    timeout = ~accept & (state_q != WAIT_FIRST)
            & (cnt_q == MAX_C - ONE_C);

    if (accept)              cnt_d = ONE_C;
    else if (cnt_q >= MAX_C) cnt_d = MAX_C;
    else                     cnt_d = cnt_q + ONE_C;

    // restoring step; the borrow bit doubles as the quotient bit
    trial = {rem_q, dvd_q[CNT_W-1]};
    diff  = trial - {1'b0, dvs_q};
    ge    = ~diff[CNT_W];
    quo_n = {dvd_q[CNT_W-2:0], ge};
    done  = (state_q == DIV) & (it_q == LAST_IT);

    hist_d = hist_q;
    sum_d  = sum_q;
    fill_d = fill_q;
    if (record) begin
      hist_d[0] = cnt_q;
      for (int i = 1; i < 4; i++) hist_d[i] = hist_q[i-1];
      sum_d = sum_q + SW'(cnt_q) - SW'(hist_q[3]);
      if (fill_q != 3'd4) fill_d = fill_q + 3'd1;
    end

    start = (record & ((state_q == TRACK)
          | ((state_q == FILL) & (fill_d == 3'd4))))
          | (done & (pend_q | record));

    state_d = state_q;
    pend_d  = pend_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    it_d    = it_q;
    hart_d  = hart_q;
    valid_d = 1'b0;
    lost_d  = lost_q;

    unique case (state_q)
      WAIT_FIRST: if (accept) state_d = FILL;
      FILL, TRACK: if (start) state_d = DIV;
      DIV: begin
        dvd_d = quo_n;
        rem_d = ge ? diff[CNT_W-1:0] : trial[CNT_W-1:0];
        it_d  = it_q + IW'(1);
        if (record) pend_d = 1'b1;
        if (done) begin
          if ((dvs_q == '0) | (|quo_n[CNT_W-1:6])) hart_d = 6'd63;
          else hart_d = quo_n[5:0];
          valid_d = 1'b1;
          lost_d  = 1'b0;
          pend_d  = 1'b0;
          state_d = start ? DIV : TRACK;
        end
      end
      default: state_d = WAIT_FIRST;
    endcase

    if (start) begin
      dvs_d = sum_d[SW-1:2];
      dvd_d = NUM_C;
      rem_d = '0;
      it_d  = '0;
    end

    if (timeout) begin
      state_d = WAIT_FIRST;
      for (int i = 0; i < 4; i++) hist_d[i] = '0;
      sum_d   = '0;
      fill_d  = '0;
      pend_d  = 1'b0;
      hart_d  = '0;
      valid_d = 1'b1;
      lost_d  = 1'b1;
    end
  end

  always_ff @(posedge slow or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      state_q <= WAIT_FIRST;
      cnt_q   <= '0;
      for (int i = 0; i < 4; i++) hist_q[i] <= '0;
      sum_q   <= '0;
      fill_q  <= '0;
      pend_q  <= 1'b0;
      dvd_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      it_q    <= '0;
      hart_q  <= '0;
      valid_q <= 1'b0;
      lost_q  <= 1'b1;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hist_q  <= hist_d;
      sum_q   <= sum_d;
      fill_q  <= fill_d;
      pend_q  <= pend_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      it_q    <= it_d;
      hart_q  <= hart_d;
      valid_q <= valid_d;
      lost_q  <= lost_d;
    end
  end

  assign hart      = hart_q;
  assign hartValid = valid_q;
  assign lost      = lost_q;
endmodule

// File: tb/tb_hart_meter.sv
// tb_hart_meter: table vectors, directed corners and random beats
// checked cycle by cycle against an interval-history reference model.
module tb_hart_meter;
  localparam int RATE_NUM = 3000;
  localparam int MIN_GAP  = 20;
  localparam int MAX_GAP  = 300;

  logic       slow  = 1'b0;
  logic       reset = 1'b1;
  logic       beat  = 1'b0;
  logic [5:0] hart, hart_f;
  logic       hartValid, lost, valid_f, lost_f;

  always #5 slow = ~slow;

  hart_meter u_dut (
    .slow(slow), .reset(reset), .beat(beat),
    .hart(hart), .hartValid(hartValid), .lost(lost)
  );

  // short refractory window so a beat can land inside a divide
  hart_meter #(.MIN_GAP(4)) u_fast (
    .slow(slow), .reset(reset), .beat(beat),
    .hart(hart_f), .hartValid(valid_f), .lost(lost_f)
  );

  int vectors = 0;
  int miscompares = 0;

  // reference model: beat times, interval queue, integer divide
  int   cyc = 0;
  logic s0 = 0, s1 = 0, s2 = 0;
  bit   armed = 0;
  int   last = 0;
  int   hist[$];
  bit   busy = 0, pend = 0;
  int   div_out = 0, m_q = 0;
  logic [5:0] e_hart = 0;
  logic e_valid = 0, e_lost = 1;

  int vcount = 0, fcount = 0;
  int fhart[4];
  int fcyc[4];

  typedef struct {
    int         period;
    logic [5:0] exp_hart;
    logic       exp_lost;
  } vec_t;
  vec_t tbl[7];

  function automatic void start_div();
    int s = 0;
    foreach (hist[i]) s += hist[i];
    s = s / 4;
    m_q = (s == 0) ? 63 : RATE_NUM / s;
    if (m_q > 63) m_q = 63;
    busy = 1;
    div_out = cyc + 12;
  endfunction

  function automatic void advance();
    bit e, acc, rec;
    e = s1 && !s2;
    acc = e && (!armed || (cyc - last) >= MIN_GAP);
    rec = acc && armed;
    e_valid = 0;
    if (!acc && armed && (cyc + 1 - last) == MAX_GAP) begin
      e_hart = 0; e_valid = 1; e_lost = 1;
      armed = 0; hist.delete(); busy = 0; pend = 0;
      return;
    end
    if (acc) begin
      if (armed) begin
        hist.push_back(cyc - last);
        if (hist.size() > 4) void'(hist.pop_front());
      end
      armed = 1;
      last = cyc;
    end
    if (busy && cyc == div_out) begin
      e_hart = 6'(m_q); e_valid = 1; e_lost = 0;
      if (pend || rec) start_div();
      else busy = 0;
      pend = 0;
    end else if (rec) begin
      if (busy) pend = 1;
      else if (hist.size() == 4) start_div();
    end
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step(input logic b);
    beat = b;
    @(posedge slow);
    s2 = s1; s1 = s0; s0 = b; cyc++;
    @(negedge slow);
    vectors++;
    if ({hart, hartValid, lost} !== {e_hart, e_valid, e_lost}) begin
      miscompares++;
      $display("FAIL cycle %0d model: got hart=%0d valid=%b lost=%b, expected hart=%0d valid=%b lost=%b",
               cyc, hart, hartValid, lost, e_hart, e_valid, e_lost);
    end
    if (hartValid) vcount++;
    if (valid_f && fcount < 4) begin
      fhart[fcount] = hart_f;
      fcyc[fcount] = cyc;
      fcount++;
    end
    advance();
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0);
  endtask

  task automatic pulse(input int w);
    for (int i = 0; i < w; i++) step(1'b1);
  endtask

  task automatic train(input int gap, input int n, input int w);
    for (int i = 0; i < n; i++) begin
      idle(gap - w);
      pulse(w);
    end
  endtask

  task automatic do_reset();
    beat = 1'b0;
    #1 reset = 1'b0;
    #1;
    vectors++;
    if ({hart, hartValid, lost} !== {6'd0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset: got hart=%0d valid=%b lost=%b, expected hart=0 valid=0 lost=1",
               hart, hartValid, lost);
    end
    s0 = 0; s1 = 0; s2 = 0;
    armed = 0; hist.delete(); busy = 0; pend = 0;
    e_hart = 0; e_valid = 0; e_lost = 1;
    @(posedge slow);
    @(posedge slow);
    @(negedge slow);
    reset = 1'b1;
  endtask

  initial begin
    tbl[0] = '{100, 6'd30, 1'b0};
    tbl[1] = '{50,  6'd60, 1'b0};
    tbl[2] = '{40,  6'd63, 1'b0};
    tbl[3] = '{20,  6'd63, 1'b0};
    tbl[4] = '{120, 6'd25, 1'b0};
    tbl[5] = '{250, 6'd12, 1'b0};
    tbl[6] = '{299, 6'd10, 1'b0};

    do_reset();
    for (int i = 0; i < 7; i++) begin
      do_reset();
      train(tbl[i].period, 5, 2);
      idle(30);
      chk($sformatf("table p%0d hart", tbl[i].period), hart, tbl[i].exp_hart);
      chk($sformatf("table p%0d lost", tbl[i].period), lost, tbl[i].exp_lost);
    end

    do_reset();
    train(100, 5, 2);
    idle(20);
    train(50, 5, 2);
    idle(20);
    chk("settle 50", hart, 60);

    do_reset();
    train(100, 3, 2);
    idle(8);
    pulse(2);
    train(90, 1, 2);
    train(100, 1, 2);
    idle(20);
    chk("glitch hart", hart, 30);

    do_reset();
    train(100, 4, 2);
    train(20, 1, 2);
    idle(20);
    chk("min gap hart", hart, 37);

    do_reset();
    train(100, 5, 2);
    idle(20);
    vcount = 0;
    idle(320);
    chk("timeout pulses", vcount, 1);
    chk("timeout hart", hart, 0);
    chk("timeout lost", lost, 1);
    train(100, 5, 2);
    idle(20);
    chk("relock hart", hart, 30);
    chk("relock lost", lost, 0);

    do_reset();
    train(100, 5, 2);
    idle(5);
    do_reset();
    vcount = 0;
    idle(30);
    chk("reset in div pulses", vcount, 0);
    chk("reset in div lost", lost, 1);

    do_reset();
    fcount = 0;
    train(100, 5, 2);
    train(6, 1, 2);
    idle(40);
    chk("mid div count", fcount, 2);
    chk("mid div first", fhart[0], 30);
    chk("mid div second", fhart[1], 39);
    chk("mid div spacing", fcyc[1] - fcyc[0], 12);
    chk("mid div lost", lost_f, 0);
    chk("mid div main hart", hart, 30);

    do_reset();
    for (int k = 0; k < 80; k++) begin
      int gap;
      int w;
      gap = $urandom_range(330, 6);
      w = $urandom_range(3, 1);
      if ($urandom_range(39, 0) == 0) do_reset();
      idle(gap - w);
      pulse(w);
    end
    idle(320);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/hart_meter.md
Name: hart_meter

Overview:
- Producer of the 6-bit `hart` sample stream that the stress-detection logic consumes on the `slow` clock.
- Measures the interval between accepted heartbeat pulses from the raw sensor input and averages the last four intervals.
- Converts the average to a scaled rate with a sequential divider and holds the result on `hart` until the next update.

Parameters:
- RATE_NUM, 3000, dividend. Default gives hart = bpm/2 at 100 Hz `slow`.
- MIN_GAP, 20, minimum accepted interval in cycles. Shorter edges are refractory glitches and are ignored.
- MAX_GAP, 300, interval in cycles without a beat that triggers the lost condition.
- CNT_W, 12, width of the interval counter and divider operands.

Ports:
- slow  input  1  system clock; all logic on its rising edge
- reset  input  1  asynchronous, active-low reset
- beat  input  1  raw, asynchronous heartbeat pulse from the sensor
- hart  output  6  scaled heart rate, held between updates
- hartValid  output  1  one-cycle pulse when `hart` is updated
- lost  output  1  high while no valid rhythm is present

Behaviour:
- Reset (reset=0, async): `hart`=0, `hartValid`=0, `lost`=1, state=WAIT_FIRST, history cleared, fill count 0, counter 0, pending 0, synchronizers 0.
- Input conditioning:
  - `beat` passes through a 2-FF synchronizer.
  - An edge is a cycle where sync stage 2 = 1 and its previous value = 0.
  - Latency from raw rise to edge: 2–3 cycles.
- Interval counter:
  - Loaded with 1 in the cycle a beat is accepted; increments every cycle after that.
  - Saturates at MAX_GAP.
  - For beats accepted in cycles A and B, the captured interval is B−A.
- Acceptance:
  - An edge is accepted in WAIT_FIRST always.
  - Otherwise it is accepted only if counter ≥ MIN_GAP. Edges at counter < MIN_GAP are ignored and the counter keeps running.
- History:
  - 4-entry interval shift register, plus a 14-bit running sum (sum of four 12-bit values).
  - On each accepted beat (not the first after WAIT_FIRST), shift in the interval, update the sum, and increment fill count (saturating at 4).
- States:
  - WAIT_FIRST: accepted edge → FILL. `lost` stays 1.
  - FILL: accepted edges record intervals. When fill count reaches 4 → DIV.
  - DIV: restoring divider, RATE_NUM / (sum>>2).
    - Exactly CNT_W iterations (12 cycles), one quotient bit per cycle.
    - On completion: `hart` = min(quotient, 63); `hartValid`=1 for one cycle; `lost`=0.
    - Then → DIV again if pending, else TRACK.
  - TRACK: accepted edge records an interval → DIV.
- Latency: the accepted beat in cycle N enters DIV at N+1, and `hart`/`hartValid` update in cycle N+13.
- Beat during DIV:
  - The interval is recorded and pending is set; the running divide completes on its latched divisor.
  - A new divide then starts immediately, clearing pending.
  - Multiple beats during one DIV collapse to a single pending.
- Divisor 0: cannot occur, since intervals ≥ MIN_GAP ≥ 1. If MIN_GAP=0 is configured, quotient is forced to 63.
- Timeout: counter reaching MAX_GAP in FILL, TRACK or DIV →
  - In that cycle: `lost`=1, `hart`=0, `hartValid`=1 for one cycle.
  - History and fill count cleared, pending cleared, any divide aborted; state → WAIT_FIRST.
  - Timeout has priority over a same-cycle divider completion.
  - No timeout in WAIT_FIRST.
- Accepted edge and timeout in the same cycle: the edge wins (counter < MAX_GAP by definition of acceptance). The counter reloads and no timeout occurs.
- Reset mid-divide: returns to the reset values above. No `hartValid` is issued.
- `hart` changes only in the cycle `hartValid` is high.

Test Plan:
- Beat every 100 cycles, 5 beats: `hartValid` pulses 13 cycles after the 5th accepted beat with `hart`=30, `lost` falls to 0 in that cycle.
- Steady 50-cycle period after lock: `hart` settles to 60 once four 50-cycle intervals are in history.
- Period 40 cycles (3000/40=75): `hart`=63 (clamped).
- Glitch 10 cycles after a beat in 100-cycle rhythm: ignored, next `hart` still 30. An edge at exactly MIN_GAP=20 is accepted (interval 20 recorded).
- Stop beats after lock: at 300 cycles, `hart`=0, `lost`=1, one `hartValid` pulse; a fresh 5-beat sequence relocks.
- Reset low during DIV: outputs immediately `hart`=0, `lost`=1, `hartValid`=0, with no pulse after release. A beat arriving mid-DIV triggers a second back-to-back divide result 12 cycles later.
